// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the requester handshake and the FIFO write/flush signals that
//   fifo_wr_arbiter sits between.
//   Modports:
//     master - arbiter view: consumes requests, fifo_full, flush_req;
//              drives req_ready, grant, fifo_wdata, fifo_wen, fifo_flush,
//              flush_done, busy.
//     slave  - environment view (requesters + FIFO), directions reversed.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       grant;
    logic [WIDTH-1:0]       fifo_wdata;
    logic                   fifo_wen;
    logic                   fifo_full;
    logic                   fifo_flush;
    logic                   flush_req;
    logic                   flush_done;
    logic                   busy;

    modport master (
        input  req_valid, req_last, req_data, fifo_full, flush_req,
        output req_ready, grant, fifo_wdata, fifo_wen, fifo_flush,
               flush_done, busy
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full, flush_req,
        input  req_ready, grant, fifo_wdata, fifo_wen, fifo_flush,
               flush_done, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one synchronous FIFO write port between N_REQ requesters with
//   burst-granular round-robin arbitration, and sequences FIFO flushes so a
//   flush never lands inside a burst.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     fifo_level  - FIFO fill level (only with FIFO_ARB_WATERMARK_EN)
//     bus         - fifo_wr_arbiter_if.master: req_valid/req_last/req_data
//                   in, req_ready/grant out, fifo_wdata/fifo_wen/fifo_flush
//                   out, fifo_full/flush_req in, flush_done/busy out
//   Optional feature: define FIFO_ARB_WATERMARK_EN to block new grants while
//   fifo_level >= HIGH_WATER.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 32,
    parameter int MAX_BURST  = 4,
    parameter int W_LEVEL    = 3,
    parameter int HIGH_WATER = 3
) (
    input logic                clk,
    input logic                rst_n,
`ifdef FIFO_ARB_WATERMARK_EN
    input logic [W_LEVEL-1:0]  fifo_level,
`endif
    fifo_wr_arbiter_if.master  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {IDLE, BURST, FLUSH, DONE} state_t;

    state_t           state;
    logic [N_REQ-1:0] grant_q;
    logic [PW-1:0]    rr_ptr;
    logic [CW-1:0]    beat_cnt;

    logic [PW-1:0]    owner;
    logic [PW-1:0]    pick_idx;
    logic             pick_found;
    logic             wm_block;
    logic             beat;
    logic             last_beat;

`ifdef FIFO_ARB_WATERMARK_EN
    always_comb wm_block = (fifo_level >= W_LEVEL'(HIGH_WATER));
`else
    // Watermark parameters stay in the parameter list so both builds share
    // one override set; they never block a grant in this build.
    localparam bit WM_PARAMS_OK = (W_LEVEL >= 0) && (HIGH_WATER >= 0);
    always_comb wm_block = !WM_PARAMS_OK;
`endif

    // Index of the one-hot owner.
    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[PW'(i)]) owner = PW'(i);
        end
    end

    // Round-robin search starting just after the last owner, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!pick_found && bus.req_valid[PW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        beat      = (state == BURST) && bus.req_valid[owner] && !bus.fifo_full;
        last_beat = beat && (bus.req_last[owner] || beat_cnt == CW'(MAX_BURST - 1));
    end

    always_comb begin
        bus.grant      = grant_q;
        bus.req_ready  = ((state == BURST) && !bus.fifo_full) ? grant_q : '0;
        bus.fifo_wen   = beat;
        bus.fifo_wdata = bus.req_data[owner * WIDTH +: WIDTH];
        bus.fifo_flush = (state == FLUSH);
        bus.flush_done = (state == DONE);
        bus.busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= '0;
            rr_ptr   <= PW'(N_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Flush wins over requests; a flush requested mid-burst
                    // is picked up here once the burst has released.
                    if (bus.flush_req) begin
                        state <= FLUSH;
                    end else if (pick_found && !wm_block) begin
                        grant_q  <= N_REQ'(1) << pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        grant_q  <= '0;
                        rr_ptr   <= owner;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                FLUSH:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. A transaction-level model
//   (current owner, beats taken, last owner, flush countdown) predicts every
//   output each cycle; directed scenarios add explicit checks on grant order,
//   burst length, backpressure, deferred flush and reset, then a random phase
//   runs against the same model.
module tb_fifo_wr_arbiter;
    localparam int N_REQ      = 4;
    localparam int WIDTH      = 32;
    localparam int MAX_BURST  = 4;
    localparam int W_LEVEL    = 3;
    localparam int HIGH_WATER = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();
`ifdef FIFO_ARB_WATERMARK_EN
    logic [W_LEVEL-1:0] fifo_level = '0;
`endif

    fifo_wr_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST),
        .W_LEVEL(W_LEVEL), .HIGH_WATER(HIGH_WATER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef FIFO_ARB_WATERMARK_EN
        .fifo_level(fifo_level),
`endif
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_owner = -1;        // -1: nobody holds the port
    int m_last  = N_REQ - 1; // requester that owned the port most recently
    int m_beats = 0;         // beats taken in the current grant
    int m_flush = 0;         // 2: flush cycle ahead, 1: done cycle ahead

    // Observations
    logic [N_REQ-1:0] prev_grant = '0;
    logic [N_REQ-1:0] dut_gq[$];
    int wen_cnt, flush_cnt, done_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit level_ok();
`ifdef FIFO_ARB_WATERMARK_EN
        return fifo_level < W_LEVEL'(HIGH_WATER);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_outputs();
        logic [N_REQ-1:0] eg;
        logic ewen;
        eg   = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
        ewen = (m_owner >= 0) && bus.req_valid[m_owner] && !bus.fifo_full;
        check_val("grant", 64'(bus.grant), 64'(eg));
        check_val("req_ready", 64'(bus.req_ready), 64'((m_owner >= 0 && !bus.fifo_full) ? eg : '0));
        check_val("fifo_wen", 64'(bus.fifo_wen), 64'(ewen));
        if (ewen) check_val("fifo_wdata", 64'(bus.fifo_wdata), 64'(bus.req_data[m_owner*WIDTH +: WIDTH]));
        check_val("fifo_flush", 64'(bus.fifo_flush), 64'(m_flush == 2));
        check_val("flush_done", 64'(bus.flush_done), 64'(m_flush == 1));
        check_val("busy", 64'(bus.busy), 64'(m_owner >= 0 || m_flush > 0));
        check_val("wen_while_full", 64'(bus.fifo_wen & bus.fifo_full), 64'(0));
        if (bus.grant != '0 && prev_grant == '0) dut_gq.push_back(bus.grant);
        prev_grant = bus.grant;
        if (bus.fifo_wen)   wen_cnt++;
        if (bus.fifo_flush) flush_cnt++;
        if (bus.flush_done) done_cnt++;
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            m_owner = -1; m_last = N_REQ - 1; m_beats = 0; m_flush = 0;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (m_owner >= 0) begin
            if (bus.req_valid[m_owner] && !bus.fifo_full) begin
                m_beats++;
                if (bus.req_last[m_owner] || m_beats == MAX_BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end else if (bus.flush_req) begin
            m_flush = 2;
        end else if (bus.req_valid != '0 && level_ok()) begin
            for (int k = 1; k <= N_REQ; k++) begin
                int idx;
                idx = (m_last + k) % N_REQ;
                if (bus.req_valid[idx]) begin
                    m_owner = idx;
                    break;
                end
            end
            m_beats = 0;
        end
    endtask

    // Inputs are already driven; check at negedge, advance model, step past edge.
    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        dut_gq.delete();
        wen_cnt = 0; flush_cnt = 0; done_cnt = 0;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        bus.flush_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 32'hA000_0000 | i;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_val("rst_grant", 64'(bus.grant), 64'(0));
        check_val("rst_busy", 64'(bus.busy), 64'(0));
        check_val("rst_wen", 64'(bus.fifo_wen), 64'(0));
        clear_obs();
    endtask

    initial begin
        logic [N_REQ-1:0] rr_exp[5];
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        idle_inputs();
        @(posedge clk); #1;
        do_reset();

        // Round-robin with single-beat bursts
        bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
        cycle(10);
        check_val("rr_count", 64'(dut_gq.size()), 64'(5));
        for (int i = 0; i < 5 && i < dut_gq.size(); i++)
            check_val($sformatf("rr_grant%0d", i), 64'(dut_gq[i]), 64'(rr_exp[i]));
        check_val("rr_writes", 64'(wen_cnt), 64'(5));

        // Burst cap: req 2 never signals last
        idle_inputs(); do_reset();
        bus.req_valid = 4'b0100;
        cycle(6);
        check_val("cap_beats", 64'(wen_cnt), 64'(MAX_BURST));
        cycle();
        check_val("cap_regrants", 64'(dut_gq.size()), 64'(2));
        if (dut_gq.size() == 2) check_val("cap_regrant", 64'(dut_gq[1]), 64'(4'b0100));

        // Backpressure on req 1
        idle_inputs(); do_reset();
        bus.req_valid = 4'b0010;
        cycle(2);
        bus.fifo_full = 1'b1;
        wen_cnt = 0;
        cycle(3);
        check_val("bp_stalled_writes", 64'(wen_cnt), 64'(0));
        bus.fifo_full = 1'b0;
        cycle(3);
        check_val("bp_resumed_writes", 64'(wen_cnt), 64'(3));
        check_val("bp_released", 64'(bus.grant), 64'(0));

        // Deferred flush; req 3 pending behind req 0
        idle_inputs(); do_reset();
        bus.req_valid = 4'b1001;
        cycle(2);
        bus.flush_req = 1'b1;
        cycle(4);
        check_val("df_beats", 64'(wen_cnt), 64'(MAX_BURST));
        check_val("df_no_flush_yet", 64'(flush_cnt), 64'(0));
        bus.flush_req = 1'b0;
        cycle(4);
        check_val("df_flushes", 64'(flush_cnt), 64'(1));
        check_val("df_dones", 64'(done_cnt), 64'(1));
        check_val("df_grants", 64'(dut_gq.size()), 64'(2));
        if (dut_gq.size() == 2) check_val("df_after_flush", 64'(dut_gq[1]), 64'(4'b1000));

        // Reset mid-burst: next grant restarts at req 0
        idle_inputs(); do_reset();
        bus.req_valid = 4'b0100;
        cycle(3);
        bus.req_valid = 4'b0101;
        do_reset();
        cycle(2);
        check_val("rmb_grant", 64'(bus.grant), 64'(4'b0001));
        check_val("rmb_no_done", 64'(done_cnt), 64'(0));

`ifdef FIFO_ARB_WATERMARK_EN
        idle_inputs(); do_reset();
        fifo_level = 3'd3;
        bus.req_valid = 4'b0001;
        cycle(3);
        check_val("wm_blocked", 64'(dut_gq.size()), 64'(0));
        fifo_level = 3'd2;
        cycle(2);
        check_val("wm_granted", 64'(bus.grant), 64'(4'b0001));
`endif

        // Randomized phase against the model
        idle_inputs(); do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = N_REQ'($urandom);
            bus.req_last  = N_REQ'($urandom_range(0, 15) & $urandom);
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            bus.flush_req = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = $urandom;
`ifdef FIFO_ARB_WATERMARK_EN
            fifo_level = W_LEVEL'($urandom);
`endif
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one synchronous FIFO between N_REQ requesters.
- Arbitration is round-robin and works on bursts: a winner keeps the port until its last beat or until MAX_BURST beats.
- The block also sequences FIFO flushes so a flush never lands in the middle of a burst.
- Sits directly in front of a sync FIFO instance and drives its wdata, wen and flush inputs.

Parameters:
N_REQ, 4, number of requesters (>= 2)
WIDTH, 32, data width
MAX_BURST, 4, maximum beats per grant (>= 1)
W_LEVEL, 3, width of the FIFO level input; used only with FIFO_ARB_WATERMARK_EN
HIGH_WATER, 3, no new grant issued while fifo_level >= HIGH_WATER; used only with FIFO_ARB_WATERMARK_EN

Ports:
clk  in  1  clock
rst_n  in  1  reset: one clock; reset is synchronous and active-low
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  per-requester last beat of burst (qualified by valid)
req_data  in  N_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  N_REQ  per-requester beat accepted
grant  out  N_REQ  one-hot current owner; all zero when no owner
fifo_wdata  out  WIDTH  to FIFO wdata
fifo_wen  out  1  to FIFO wen
fifo_full  in  1  from FIFO full
fifo_flush  out  1  to FIFO flush
flush_req  in  1  level request to flush the FIFO
flush_done  out  1  one-cycle pulse: flush complete
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BURST, FLUSH, DONE. Registers: state, grant, rr_ptr (last owner index), beat_cnt.
- Reset (rst_n low at a clk edge): state=IDLE, grant=0, rr_ptr=N_REQ-1, beat_cnt=0.
  - All outputs then read 0: req_ready, fifo_wen, fifo_flush, flush_done, busy. fifo_wdata is don't-care.
  - Reset mid-burst or mid-flush aborts immediately; no flush_done is produced.
- IDLE:
  - flush_req=1 -> FLUSH. Flush has priority over all requests.
  - Otherwise, if any req_valid is set, pick the first set bit searching from index rr_ptr+1 upward, wrapping modulo N_REQ.
  - Register the winner's one-hot into grant, clear beat_cnt, go to BURST.
  - Arbitration latency is 1 cycle: no beat transfers in IDLE.
- BURST:
  - o = owner index.
  - req_ready[o] = !fifo_full. Every other req_ready is 0.
  - fifo_wen = req_valid[o] && !fifo_full.
  - fifo_wdata = req_data[o] (combinational mux).
  - Beat = req_valid[o] && req_ready[o]. On each beat, beat_cnt increments.
  - Burst ends when a beat has req_last[o]=1 or beat_cnt==MAX_BURST-1. At the end: grant=0, rr_ptr=o, next state IDLE.
  - The owner dropping req_valid mid-burst does not release the grant; the block waits.
  - fifo_full stalls the burst; beat_cnt holds.
- FLUSH: fifo_flush=1 for exactly one cycle, then DONE.
- DONE: flush_done=1 for one cycle, then IDLE.
  - flush_req is sampled again in IDLE. A requester still holding flush_req there gets a second flush.
- flush_req asserted during BURST: deferred until the burst ends. IDLE then takes the flush ahead of any pending request.
- The FIFO is never written on a full cycle. fifo_wen && fifo_full is never 1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. Each grant carries at most MAX_BURST beats.

Optional Feature:
Macro FIFO_ARB_WATERMARK_EN.
- When defined:
  - Adds input port fifo_level [W_LEVEL-1:0], driven from the FIFO level output.
  - IDLE issues no new grant while fifo_level >= HIGH_WATER. The flush path is unaffected.
  - A burst already in progress continues, gated only by fifo_full.
- When undefined:
  - The port is absent and W_LEVEL/HIGH_WATER are ignored.
  - Grants depend only on req_valid and flush_req.

Test Plan:
- Reset mid-burst: assert rst_n=0 for 1 cycle after 2 beats -> next cycle state IDLE, grant=0, busy=0, fifo_wen=0; rr_ptr=N_REQ-1, so the next grant goes to req 0 if valid.
- Round-robin: req_valid=4'b1111, single-beat bursts (req_last=1), fifo_full=0 -> grant sequence 0001,0010,0100,1000,0001. Each grant is preceded by 1 IDLE cycle. fifo_wdata matches the owner's data.
- Burst cap: req 2 valid, req_last=0, MAX_BURST=4 -> exactly 4 beats written, then IDLE, then regrant to req 2 if it is the only one valid.
- Backpressure: during a req 1 burst, fifo_full=1 for 3 cycles -> req_ready=0, fifo_wen=0, beat_cnt holds; writes resume on the cycle fifo_full falls; the FIFO receives no write while full.
- Deferred flush: flush_req=1 at beat 2 of a 4-beat burst -> remaining beats complete; then IDLE, FLUSH (fifo_flush=1 for one cycle), DONE (flush_done=1). A pending req_valid[3] is granted only after DONE.
- Watermark (FIFO_ARB_WATERMARK_EN, HIGH_WATER=3): fifo_level=3 with req 0 valid -> stays IDLE, grant=0; fifo_level drops to 2 -> grant=0001 the next cycle.
